// File: rtl/psr_pkg.sv
// psr_pkg: mode encodings, PSR field positions and mode helpers.
// Optional Thumb state storage is enabled by defining PSR_THUMB_EN.
package psr_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam int N_BIT = 31;
    localparam int Z_BIT = 30;
    localparam int C_BIT = 29;
    localparam int V_BIT = 28;
    localparam int I_BIT = 7;
    localparam int F_BIT = 6;
    localparam int T_BIT = 5;
    localparam int M_MSB = 4;
    localparam int M_LSB = 0;

    localparam int MASK_F = 3;
    localparam int MASK_S = 2;
    localparam int MASK_X = 1;
    localparam int MASK_C = 0;

    localparam int NUM_BANKS = 5;

`ifdef PSR_THUMB_EN
    localparam logic [31:0] PSR_KEEP = 32'hF000_00FF;
`else
    localparam logic [31:0] PSR_KEEP = 32'hF000_00DF;
`endif

    function automatic logic is_banked_mode(input logic [4:0] m);
        return (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC) ||
               (m == MODE_ABT) || (m == MODE_UND);
    endfunction

    function automatic logic is_legal_mode(input logic [4:0] m);
        return is_banked_mode(m) || (m == MODE_USR) || (m == MODE_SYS);
    endfunction

    function automatic logic [2:0] mode_to_bank(input logic [4:0] m);
        logic [2:0] b;
        b = 3'd0;
        unique case (m)
            MODE_FIQ: b = 3'd0;
            MODE_IRQ: b = 3'd1;
            MODE_SVC: b = 3'd2;
            MODE_ABT: b = 3'd3;
            MODE_UND: b = 3'd4;
            default:  b = 3'd0;
        endcase
        return b;
    endfunction

    // Drops reserved bits (and T when Thumb is not built in).
    function automatic logic [31:0] psr_clean(input logic [31:0] v);
        return v & PSR_KEEP;
    endfunction

endpackage

// File: rtl/psr_bank_if.sv
// psr_bank_if: request and status bundle between pipeline and PSR bank.
// master drives requests, slave is the PSR bank.
interface psr_bank_if;
    logic        en;
    logic        i_nzcv_flag;
    logic [3:0]  i_nzcv_alu;
    logic        i_msr_valid;
    logic        i_msr_spsr;
    logic [3:0]  i_msr_mask;
    logic [31:0] i_msr_data;
    logic        i_exc_valid;
    logic [4:0]  i_exc_mode;
    logic        i_ret_valid;
    logic [31:0] o_cpsr;
    logic [31:0] o_cpsr_next;
    logic [31:0] o_spsr;
    logic [4:0]  o_mode;
    logic        o_privileged;
    logic        o_mode_err;

    modport master (
        output en, i_nzcv_flag, i_nzcv_alu, i_msr_valid, i_msr_spsr,
        output i_msr_mask, i_msr_data, i_exc_valid, i_exc_mode, i_ret_valid,
        input  o_cpsr, o_cpsr_next, o_spsr, o_mode, o_privileged, o_mode_err
    );

    modport slave (
        input  en, i_nzcv_flag, i_nzcv_alu, i_msr_valid, i_msr_spsr,
        input  i_msr_mask, i_msr_data, i_exc_valid, i_exc_mode, i_ret_valid,
        output o_cpsr, o_cpsr_next, o_spsr, o_mode, o_privileged, o_mode_err
    );
endinterface

// File: rtl/psr_mode_decode.sv
// psr_mode_decode: classifies a 5-bit mode field.
// Pure combinational; bank index is 0 for non-banked modes.
module psr_mode_decode
    import psr_pkg::*;
(
    input  logic [4:0] mode,
    output logic       legal,
    output logic       banked,
    output logic [2:0] bank_idx,
    output logic       privileged
);

    assign legal      = is_legal_mode(mode);
    assign banked     = is_banked_mode(mode);
    assign bank_idx   = mode_to_bank(mode);
    assign privileged = (mode != MODE_USR);

endmodule

// File: rtl/psr_bank.sv
// psr_bank: CPSR plus five banked SPSRs with exception entry/return.
// Define PSR_THUMB_EN to store the T bit; otherwise T reads 0.
module psr_bank
    import psr_pkg::*;
#(
    parameter logic [4:0]  RESET_MODE = 5'b10011,
    parameter logic [1:0]  RESET_IF   = 2'b11,
    parameter logic [31:0] SPSR_RESET = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst_n,
    psr_bank_if.slave  bus
);

    logic [31:0] cpsr;
    logic [31:0] spsr [NUM_BANKS];
    logic        mode_err;

    logic        cur_legal, cur_banked, cur_priv;
    logic [2:0]  cur_bank;
    logic        tgt_legal, tgt_banked, tgt_priv;
    logic [2:0]  tgt_bank;
    logic [4:0]  tgt_mode;
    logic [31:0] spsr_cur;

    logic [31:0] cpsr_n;
    logic        spsr_we;
    logic [2:0]  spsr_idx;
    logic [31:0] spsr_wd;
    logic        err_n;

    psr_mode_decode u_cur (
        .mode       (cpsr[M_MSB:M_LSB]),
        .legal      (cur_legal),
        .banked     (cur_banked),
        .bank_idx   (cur_bank),
        .privileged (cur_priv)
    );

    psr_mode_decode u_tgt (
        .mode       (tgt_mode),
        .legal      (tgt_legal),
        .banked     (tgt_banked),
        .bank_idx   (tgt_bank),
        .privileged (tgt_priv)
    );

    assign spsr_cur = cur_banked ? spsr[cur_bank] : 32'h0;

    // Second decoder looks at whichever mode the winning request installs.
    always_comb begin
        tgt_mode = bus.i_msr_data[M_MSB:M_LSB];
        if (bus.i_exc_valid)
            tgt_mode = bus.i_exc_mode;
        else if (bus.i_ret_valid)
            tgt_mode = spsr_cur[M_MSB:M_LSB];
    end

    // Next-state: one winner per cycle, exc > ret > msr > nzcv.
    always_comb begin
        cpsr_n   = cpsr;
        spsr_we  = 1'b0;
        spsr_idx = cur_bank;
        spsr_wd  = spsr_cur;
        err_n    = 1'b0;
        if (bus.i_exc_valid) begin
            if (tgt_banked) begin
                spsr_we  = 1'b1;
                spsr_idx = tgt_bank;
                spsr_wd  = cpsr;
                cpsr_n[M_MSB:M_LSB] = bus.i_exc_mode;
                cpsr_n[I_BIT] = 1'b1;
                cpsr_n[T_BIT] = 1'b0;
                if (bus.i_exc_mode == MODE_FIQ)
                    cpsr_n[F_BIT] = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end else if (bus.i_ret_valid) begin
            if (cur_banked) begin
                cpsr_n = spsr_cur;
                if (!tgt_legal) begin
                    cpsr_n[M_MSB:M_LSB] = cpsr[M_MSB:M_LSB];
                    err_n = 1'b1;
                end
            end else begin
                err_n = 1'b1;
            end
        end else if (bus.i_msr_valid) begin
            if (bus.i_msr_spsr) begin
                if (cur_banked) begin
                    spsr_we = 1'b1;
                    if (bus.i_msr_mask[MASK_F])
                        spsr_wd[31:28] = bus.i_msr_data[31:28];
                    if (bus.i_msr_mask[MASK_C])
                        spsr_wd[7:0] = bus.i_msr_data[7:0];
                end else begin
                    err_n = 1'b1;
                end
            end else begin
                if (bus.i_msr_mask[MASK_F])
                    cpsr_n[31:28] = bus.i_msr_data[31:28];
                if (bus.i_msr_mask[MASK_C] && cur_priv) begin
                    cpsr_n[7:5] = bus.i_msr_data[7:5];
                    if (tgt_legal)
                        cpsr_n[M_MSB:M_LSB] = tgt_mode;
                    else
                        err_n = 1'b1;
                end
            end
        end else if (bus.i_nzcv_flag) begin
            cpsr_n[31:28] = bus.i_nzcv_alu;
        end
        cpsr_n  = psr_clean(cpsr_n);
        spsr_wd = psr_clean(spsr_wd);
    end

    // State registers: synchronous reset, update only on pipeline advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpsr     <= {4'b0, 20'b0, RESET_IF, 1'b0, RESET_MODE};
            mode_err <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++)
                spsr[i] <= psr_clean(SPSR_RESET);
        end else if (bus.en) begin
            cpsr     <= cpsr_n;
            mode_err <= err_n;
            if (spsr_we)
                spsr[spsr_idx] <= spsr_wd;
        end else begin
            mode_err <= 1'b0;
        end
    end

    assign bus.o_cpsr       = cpsr;
    assign bus.o_cpsr_next  = cpsr_n;
    assign bus.o_spsr       = spsr_cur;
    assign bus.o_mode       = cpsr[M_MSB:M_LSB];
    assign bus.o_privileged = cur_priv;
    assign bus.o_mode_err   = mode_err;

endmodule

// File: tb/tb_psr_bank.sv
// tb_psr_bank: vector table plus directed sequences for psr_bank.
module tb_psr_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    psr_bank_if bus ();

    psr_bank u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        nzcv;
        logic [3:0]  alu;
        logic        msr;
        logic        msr_spsr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        exc;
        logic [4:0]  exc_mode;
        logic        ret;
        logic [31:0] exp_cpsr;
        logic [31:0] exp_spsr;
        logic        exp_priv;
        logic        exp_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.en          = 1'b1;
        bus.i_nzcv_flag = 1'b0;
        bus.i_nzcv_alu  = 4'h0;
        bus.i_msr_valid = 1'b0;
        bus.i_msr_spsr  = 1'b0;
        bus.i_msr_mask  = 4'h0;
        bus.i_msr_data  = 32'h0;
        bus.i_exc_valid = 1'b0;
        bus.i_exc_mode  = 5'h0;
        bus.i_ret_valid = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        idle();
        bus.i_nzcv_flag = v.nzcv;
        bus.i_nzcv_alu  = v.alu;
        bus.i_msr_valid = v.msr;
        bus.i_msr_spsr  = v.msr_spsr;
        bus.i_msr_mask  = v.mask;
        bus.i_msr_data  = v.data;
        bus.i_exc_valid = v.exc;
        bus.i_exc_mode  = v.exc_mode;
        bus.i_ret_valid = v.ret;
        @(posedge clk);
        #1;
        idle();
        #1;
        chk({v.name, ".cpsr"}, bus.o_cpsr, v.exp_cpsr);
        chk({v.name, ".spsr"}, bus.o_spsr, v.exp_spsr);
        chk({v.name, ".priv"}, 32'(bus.o_privileged), 32'(v.exp_priv));
        chk({v.name, ".err"}, 32'(bus.o_mode_err), 32'(v.exp_err));
        chk({v.name, ".mode"}, 32'(bus.o_mode), 32'(v.exp_cpsr[4:0]));
    endtask

    initial begin
        //        name      nz alu msr sp mask  data           exc mode     ret cpsr           spsr           pv er
        vt[0]  = '{"msr_c",  0, 0,  1, 0, 4'h9, 32'h6000_0013, 0, 5'h00,    0, 32'h6000_0013, 32'h0,         1, 0};
        vt[1]  = '{"exc_irq",0, 0,  0, 0, 4'h0, 32'h0,         1, 5'b10010, 0, 32'h6000_0092, 32'h6000_0013, 1, 0};
        vt[2]  = '{"ret_irq",0, 0,  0, 0, 4'h0, 32'h0,         0, 5'h00,    1, 32'h6000_0013, 32'h0,         1, 0};
        vt[3]  = '{"exc_fiq",1, 15, 0, 0, 4'h0, 32'h0,         1, 5'b10001, 0, 32'h6000_00D1, 32'h6000_0013, 1, 0};
        vt[4]  = '{"msr_sf", 0, 0,  1, 1, 4'h8, 32'hA000_0000, 0, 5'h00,    0, 32'h6000_00D1, 32'hA000_0013, 1, 0};
        vt[5]  = '{"nzcv",   1, 5,  0, 0, 4'h0, 32'h0,         0, 5'h00,    0, 32'h5000_00D1, 32'hA000_0013, 1, 0};
        vt[6]  = '{"ret_fiq",0, 0,  0, 0, 4'h0, 32'h0,         0, 5'h00,    1, 32'hA000_0013, 32'h0,         1, 0};
        vt[7]  = '{"exc_bad",0, 0,  0, 0, 4'h0, 32'h0,         1, 5'b10100, 0, 32'hA000_0013, 32'h0,         1, 1};
        vt[8]  = '{"exc_sys",0, 0,  0, 0, 4'h0, 32'h0,         1, 5'b11111, 0, 32'hA000_0013, 32'h0,         1, 1};
        vt[9]  = '{"msr_badm",0,0,  1, 0, 4'h1, 32'h0000_00D4, 0, 5'h00,    0, 32'hA000_00D3, 32'h0,         1, 1};
        vt[10] = '{"to_usr", 0, 0,  1, 0, 4'h1, 32'h0000_0010, 0, 5'h00,    0, 32'hA000_0010, 32'h0,         0, 0};
        vt[11] = '{"usr_msr",0, 0,  1, 0, 4'h9, 32'hF000_001F, 0, 5'h00,    0, 32'hF000_0010, 32'h0,         0, 0};
        vt[12] = '{"usr_sp", 0, 0,  1, 1, 4'h9, 32'h1234_5678, 0, 5'h00,    0, 32'hF000_0010, 32'h0,         0, 1};
        vt[13] = '{"usr_ret",0, 0,  0, 0, 4'h0, 32'h0,         0, 5'h00,    1, 32'hF000_0010, 32'h0,         0, 1};
        vt[14] = '{"exc_und",0, 0,  0, 0, 4'h0, 32'h0,         1, 5'b11011, 0, 32'hF000_009B, 32'hF000_0010, 1, 0};
        vt[15] = '{"sp_badm",0, 0,  1, 1, 4'h1, 32'h0000_0014, 0, 5'h00,    0, 32'hF000_009B, 32'hF000_0014, 1, 0};
        vt[16] = '{"ret_bad",0, 0,  0, 0, 4'h0, 32'h0,         0, 5'h00,    1, 32'hF000_001B, 32'hF000_0014, 1, 1};
        vt[17] = '{"msr_win",1, 12, 1, 0, 4'h8, 32'h3000_0000, 0, 5'h00,    0, 32'h3000_001B, 32'hF000_0014, 1, 0};

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.cpsr", bus.o_cpsr, 32'h0000_00D3);
        chk("rst.next", bus.o_cpsr_next, 32'h0000_00D3);
        chk("rst.spsr", bus.o_spsr, 32'h0);
        chk("rst.priv", 32'(bus.o_privileged), 32'd1);
        chk("rst.err", 32'(bus.o_mode_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            apply(vt[i]);

        // Stalled pipeline: registered CPSR holds, next-value shows flags.
        @(negedge clk);
        idle();
        bus.en          = 1'b0;
        bus.i_nzcv_flag = 1'b1;
        bus.i_nzcv_alu  = 4'hA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall.cpsr", bus.o_cpsr, 32'h3000_001B);
            chk("stall.next", bus.o_cpsr_next, 32'hA000_001B);
        end
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        chk("advance.cpsr", bus.o_cpsr, 32'hA000_001B);

        // Illegal request while stalled: dropped, no error.
        @(negedge clk);
        idle();
        bus.en          = 1'b0;
        bus.i_exc_valid = 1'b1;
        bus.i_exc_mode  = 5'b10100;
        @(posedge clk);
        #1;
        chk("stall_exc.err", 32'(bus.o_mode_err), 32'd0);
        chk("stall_exc.cpsr", bus.o_cpsr, 32'hA000_001B);

        // Error pulse lasts exactly one cycle.
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        idle();
        chk("pulse.err1", 32'(bus.o_mode_err), 32'd1);
        @(posedge clk);
        #1;
        chk("pulse.err0", 32'(bus.o_mode_err), 32'd0);

        // Reset landing on the pulse cycle clears it.
        @(negedge clk);
        bus.i_exc_valid = 1'b1;
        bus.i_exc_mode  = 5'b10100;
        @(posedge clk);
        #1;
        idle();
        chk("rpulse.err1", 32'(bus.o_mode_err), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rpulse.err0", 32'(bus.o_mode_err), 32'd0);
        chk("rpulse.cpsr", bus.o_cpsr, 32'h0000_00D3);
        @(negedge clk);
        rst_n = 1'b1;

        // SPSR banks are cleared by reset.
        apply('{"rst_bank", 0, 0, 1, 0, 4'h1, 32'h0000_00D7, 0, 5'h00, 0,
                32'h0000_00D7, 32'h0, 1, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
